// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first WIDTH-bit subtractor (a - b): one full-subtractor cell
// plus a borrow flip-flop, one bit per clock, start/done handshake.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt_q;
    logic             br_q;
    logic             borrow_q;
    logic             busy_q;
    logic             done_q;

    logic             ai;
    logic             bi;
    logic             d_bit;
    logic             bo;

    // Full-subtractor cell operating on the current LSBs and the stored borrow.
    always_comb begin
        ai    = a_q[0];
        bi    = b_q[0];
        d_bit = ai ^ bi ^ br_q;
        bo    = (~ai & bi) | (~(ai ^ bi) & br_q);
        r_d   = {d_bit, r_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        r_q     <= '0;
                        br_q    <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    r_q   <= r_d;
                    br_q  <= bo;
                    cnt_q <= cnt_q + CW'(1);
                    // Last bit: publish the result including the bit computed now.
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        diff_q   <= r_d;
                        borrow_q <= bo;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed checks of serial_subtractor at WIDTH=8 and WIDTH=16
// against a plain-arithmetic reference of unsigned subtraction.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start8, start16;
    logic [7:0]  a8, b8, diff8;
    logic [15:0] a16, b16, diff16;
    logic        busy8, done8, borrow8;
    logic        busy16, done16, borrow16;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
    );

    serial_subtractor #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .diff(diff16), .borrow(borrow16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int w, output logic dn, output logic bz,
                          output logic [31:0] d, output logic br);
        if (w == 8) begin
            dn = done8;  bz = busy8;  d = {24'd0, diff8};  br = borrow8;
        end else begin
            dn = done16; bz = busy16; d = {16'd0, diff16}; br = borrow16;
        end
    endtask

    task automatic drive(input int w, input logic s, input logic [31:0] av, input logic [31:0] bv);
        if (w == 8) begin
            start8 = s; a8 = av[7:0]; b8 = bv[7:0];
        end else begin
            start16 = s; a16 = av[15:0]; b16 = bv[15:0];
        end
    endtask

    // One full operation; operands are scrambled after acceptance, and
    // optionally a competing start is pulsed while the unit is running.
    task automatic do_op(input int w, input logic [31:0] av, input logic [31:0] bv,
                         input string tag, input bit inject);
        logic [31:0] mask, exp_d, got_d;
        logic        exp_b, got_b, dn, bz;
        int          cyc;
        mask  = (32'd1 << w) - 32'd1;
        exp_d = (av - bv) & mask;
        exp_b = ((av & mask) < (bv & mask));
        drive(w, 1'b1, av, bv);
        @(negedge clk);
        drive(w, 1'b0, $urandom, $urandom);
        cyc = 1;
        sample(w, dn, bz, got_d, got_b);
        chk({tag, "_busy"}, bz, 1);
        while (!dn && cyc < w + 8) begin
            @(negedge clk);
            cyc++;
            if (inject && cyc == 3) drive(w, 1'b1, ~av, bv ^ 32'h5);
            if (inject && cyc == 4) drive(w, 1'b0, $urandom, $urandom);
            sample(w, dn, bz, got_d, got_b);
        end
        chk({tag, "_lat"}, cyc, w + 1);
        chk({tag, "_diff"}, got_d, exp_d);
        chk({tag, "_borrow"}, got_b, exp_b);
        @(negedge clk);
        sample(w, dn, bz, got_d, got_b);
        chk({tag, "_done_fall"}, {bz, dn}, 2'b00);
        chk({tag, "_hold"}, {got_b, got_d}, {exp_b, exp_d});
        if (inject) begin
            repeat (2) begin
                @(negedge clk);
                sample(w, dn, bz, got_d, got_b);
                chk({tag, "_not_queued"}, {bz, dn}, 2'b00);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses, last_t, t;
        rst_n = 1'b0;
        drive(8, 1'b0, 0, 0);
        drive(16, 1'b0, 0, 0);
        repeat (2) @(negedge clk);
        chk("rst8", {busy8, done8, borrow8, diff8}, '0);
        chk("rst16", {busy16, done16, borrow16, diff16}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(8, 5, 3, "t5m3", 1'b0);
        do_op(8, 3, 5, "t3m5", 1'b0);
        do_op(8, 8'h00, 8'h01, "t0m1", 1'b0);
        do_op(8, 8'h00, 8'h00, "t0m0", 1'b0);
        do_op(8, 8'hA5, 8'hA5, "tA5", 1'b0);
        do_op(8, 8'hFF, 8'h00, "tFF", 1'b0);
        do_op(8, 8'h30, 8'h10, "tmid", 1'b1);
        do_op(16, 16'h0000, 16'hFFFF, "t16_edge", 1'b0);

        // start held high: one result every WIDTH+2 cycles
        drive(8, 1'b1, 9, 4);
        pulses = 0; last_t = 0;
        for (t = 1; t <= 60 && pulses < 3; t++) begin
            @(negedge clk);
            if (done8) begin
                chk("held_diff", {borrow8, diff8}, 9'h005);
                if (pulses > 0) chk("held_period", t - last_t, 10);
                last_t = t;
                pulses++;
            end
        end
        chk("held_pulses", pulses, 3);
        drive(8, 1'b0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("held_stop", {busy8, done8}, 2'b00);

        // reset in the middle of an operation aborts it
        drive(8, 1'b1, 8'h80, 8'h01);
        @(negedge clk);
        drive(8, 1'b0, 0, 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_state", {busy8, done8, borrow8, diff8}, '0);
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) pulses++;
        end
        chk("abort_no_done", pulses, 0);
        do_op(8, 8'h80, 8'h01, "t80m1", 1'b0);

        for (int i = 0; i < 1000; i++) begin
            do_op(8, $urandom, $urandom, "rnd8", 1'b0);
            do_op(16, $urandom, $urandom, "rnd16", 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first WIDTH-bit subtractor (a - b).
- Built around a single full-subtractor cell plus a borrow flip-flop. It is the inverse-operation counterpart of the team's adder cells.
- Trades latency for area: one bit per clock, start/done handshake.
- Used as a standalone arithmetic unit in the advanced digital design labs and as a building block for the later serial ALU.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- start  input  1  request to begin a subtraction; accepted only in IDLE.
- a  input  WIDTH  minuend; sampled on the accepting edge only.
- b  input  WIDTH  subtrahend; sampled on the accepting edge only.
- busy  output  1  high while the subtraction is in progress (RUN state).
- done  output  1  one-cycle pulse when diff and borrow are updated.
- diff  output  WIDTH  result (a - b) mod 2^WIDTH; holds its value between operations.
- borrow  output  1  final borrow out; 1 iff a < b (unsigned); holds its value between operations.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State goes to IDLE.
  - busy=0, done=0, diff=0, borrow=0.
  - Internal shift registers, bit counter and borrow flip-flop are cleared.
- Reset has priority over all other inputs.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at an edge: latch a into shift register A and b into shift register B, clear the borrow flip-flop, set the bit counter to 0, and go to RUN.
  - busy=1 from that edge.
- RUN, on each edge:
  - Take ai=A[0], bi=B[0], br=borrow flip-flop.
  - d = ai ^ bi ^ br.
  - bo = (~ai & bi) | (~(ai ^ bi) & br).
  - Shift A and B right by one. Shift d into the MSB of the result shift register R, which shifts right.
  - Borrow flip-flop <= bo. Counter += 1.
  - When the counter reaches WIDTH-1 at this edge (the last bit): load diff <= final R contents (including this bit) and borrow <= bo, set done=1 and busy=0, and go to DONE.
- DONE:
  - Lasts exactly one cycle, then IDLE unconditionally. done=0 on exit.
- Latency: start accepted at edge k. done is high for the single cycle after edge k+WIDTH, and diff/borrow are valid from that edge onward.
- start while in RUN or DONE is ignored; it is not queued.
- a and b may change freely after the accepting edge without affecting the result.
- diff and borrow change only at the completion edge or at reset; they are stable for all other cycles.
- Throughput: back-to-back operation is one result per WIDTH+2 cycles (start re-asserted in the IDLE cycle after DONE).
- Reset during RUN aborts the operation: no done pulse, and diff and borrow are cleared to 0.
- Arithmetic is unsigned modulo 2^WIDTH. The output borrow equals the borrow out of the MSB cell.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- WIDTH=8, a=5, b=3, start pulse -> busy high for 8 cycles, then done for one cycle with diff=0x02 and borrow=0.
- a=3, b=5 -> diff=0xFE, borrow=1. Then a=0x00, b=0x01 -> diff=0xFF, borrow=1. Then a=0x00, b=0x00 -> diff=0x00, borrow=0.
- a=0xA5, b=0xA5 -> diff=0x00, borrow=0. Then a=0xFF, b=0x00 -> diff=0xFF, borrow=0. Also check that operands changed after the accepting edge do not alter the result.
- start=1 held continuously with a=9, b=4 -> results 0x05 every 10 cycles. Also check that a start pulse mid-RUN with different operands is ignored.
- rst_n=0 for one edge at bit 4 of a=0x80, b=0x01 -> state IDLE, no done pulse, diff=0, borrow=0. A following start with a=0x80, b=0x01 gives diff=0x7F, borrow=0.
- Random sweep (1000 operand pairs, WIDTH=8 and WIDTH=16) -> each result matches {borrow,diff} = {a<b, (a-b) mod 2^WIDTH} against a reference model.
